main: RTL and testbench

Eight-bit, four-entry LIFO calculator stack for a small arithmetic datapath. On each clock where `apply` is high, it executes one of seven operations selected by `op`: push `in`, pop, or replace the top two entries with their sum, product, difference, quotient or remainder. It exposes the top-of-stack (`tail`), an `empty` flag and a sticky `valid` flag that drops on overflow, underflow or division by zero.

---
 rtl/main.sv | 99 +++++++++
 tb/tb_main.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/main.sv
// Four-entry, eight-bit LIFO calculator stack. Supports push and pop, plus
// binary ops that replace the top two entries; a sticky error flag is cleared only by reset.
module main #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       op,
  input  logic             apply,
  output logic [WIDTH-1:0] tail,
  output logic             valid,
  output logic             empty,
  input  logic             clk,
  input  logic             reset
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_ADD  = 3'd2,
    OP_MUL  = 3'd3,
    OP_SUB  = 3'd4,
    OP_DIV  = 3'd5,
    OP_MOD  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_cnt;
  logic             r_err;

  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_nxt_idx;
  logic [AW-1:0]    w_push_idx;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_n;
  logic [WIDTH-1:0] w_res;
  logic             w_is_div;
  logic             w_binary;

  // T and N are only meaningful once cnt covers them; callers guard on r_cnt.
  assign w_top_idx  = AW'(r_cnt - CW'(1));
  assign w_nxt_idx  = AW'(r_cnt - CW'(2));
  assign w_push_idx = AW'(r_cnt);
  assign w_t        = r_mem[w_top_idx];
  assign w_n        = r_mem[w_nxt_idx];
  assign w_is_div   = (op == OP_DIV) || (op == OP_MOD);
  assign w_binary   = (op >= OP_ADD) && (op <= OP_MOD);

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_res = '0;
    case (op)
      OP_ADD:  w_res = w_t + w_n;
      OP_MUL:  w_res = w_t * w_n;
      OP_SUB:  w_res = w_t - w_n;
      OP_DIV:  w_res = (w_n != '0) ? w_t / w_n : '0;
      OP_MOD:  w_res = (w_n != '0) ? w_t % w_n : '0;
      default: w_res = '0;
    endcase
  end

  // NOTE: state uses non-blocking assignments, so every branch reads pre-edge values of r_cnt/r_mem.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
      // NOTE: the entries are cleared too, so the array cannot map to a reset-less RAM; at this depth that is intended.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (apply && !r_err) begin
      if (op == OP_PUSH) begin
        if (r_cnt == CW'(DEPTH)) begin
          r_err <= 1'b1;
        end else begin
          r_mem[w_push_idx] <= in;
          r_cnt             <= r_cnt + CW'(1);
        end
      end else if (op == OP_POP) begin
        if (r_cnt == '0) r_err <= 1'b1;
        else             r_cnt <= r_cnt - CW'(1);
      end else if (w_binary) begin
        if (r_cnt < CW'(2) || (w_is_div && w_n == '0)) begin
          r_err <= 1'b1;
        end else begin
          r_mem[w_nxt_idx] <= w_res;
          r_cnt            <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign tail  = (r_cnt != '0) ? w_t : '0;
  assign empty = (r_cnt == '0);
  assign valid = !r_err;

endmodule

// File: tb/tb_main.sv
// Bench for the calculator stack: queue-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_main;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in;
  logic [2:0] op;
  logic       apply;
  logic [7:0] tail;
  logic       valid;
  logic       empty;

  int errors = 0;
  int checks = 0;

  // Reference model: plain queue of values, top at the back.
  int unsigned m_stk[$];
  bit          m_err;
  bit          m_known = 1'b0;

  main #(.DEPTH(4), .WIDTH(8)) dut (
    .in(in), .op(op), .apply(apply), .tail(tail),
    .valid(valid), .empty(empty), .clk(clk), .reset(reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit a, input int o, input int d);
    int unsigned t, n, res;
    if (r) begin
      m_stk.delete();
      m_err   = 1'b0;
      m_known = 1'b1;
      return;
    end
    if (!a || m_err) return;
    case (o)
      0: if (m_stk.size() >= 4) m_err = 1'b1; else m_stk.push_back(d & 255);
      1: if (m_stk.size() == 0) m_err = 1'b1; else void'(m_stk.pop_back());
      2, 3, 4, 5, 6: begin
        if (m_stk.size() < 2) begin
          m_err = 1'b1;
        end else begin
          t = m_stk[m_stk.size()-1];
          n = m_stk[m_stk.size()-2];
          if ((o == 5 || o == 6) && n == 0) begin
            m_err = 1'b1;
          end else begin
            case (o)
              2: res = t + n;
              3: res = t * n;
              4: res = t - n;
              5: res = t / n;
              default: res = t % n;
            endcase
            void'(m_stk.pop_back());
            m_stk[m_stk.size()-1] = res & 255;
          end
        end
      end
      default: ;
    endcase
  endfunction

  // Compare process: outputs are stable mid-cycle, checked against the model.
  always @(negedge clk) begin
    if (m_known) begin
      check("model_tail",  tail,  (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 0);
      check("model_empty", empty, (m_stk.size() == 0));
      check("model_valid", valid, !m_err);
    end
  end

  task automatic cyc(input bit r, input bit a, input int o, input int d);
    reset = r; apply = a; op = 3'(o); in = 8'(d);
    @(posedge clk);
    model_step(r, a, o, d);
    #1;
  endtask

  task automatic rst();           cyc(1, 0, 0, 0); endtask
  task automatic push(input int d); cyc(0, 1, 0, d); endtask
  task automatic doop(input int o); cyc(0, 1, o, 0); endtask

  int arith_op  [5] = '{2, 3, 4, 5, 6};
  int arith_exp [5] = '{8, 16, 0, 1, 0};

  initial begin
    reset = 1'b1; apply = 1'b0; op = '0; in = '0;

    // Reset and hold with apply low
    rst();
    check("rst_empty", empty, 1);
    check("rst_valid", valid, 1);
    check("rst_tail",  tail,  0);
    cyc(0, 0, 0, 4);
    cyc(0, 0, 0, 4);
    check("hold_empty", empty, 1);
    check("hold_tail",  tail,  0);
    cyc(0, 1, 0, 4);
    check("push1_tail",  tail,  4);
    check("push1_empty", empty, 0);
    check("push1_valid", valid, 1);

    // Overflow
    rst();
    repeat (4) push(4);
    check("full_valid", valid, 1);
    push(4);
    check("ovf_valid", valid, 0);
    check("ovf_empty", empty, 0);
    check("ovf_tail",  tail,  4);
    rst();
    check("ovf_rst_empty", empty, 1);
    check("ovf_rst_valid", valid, 1);

    // Binary ops on 4,4
    foreach (arith_op[i]) begin
      push(4); push(4);
      doop(arith_op[i]);
      check($sformatf("op%0d_tail", arith_op[i]), tail, arith_exp[i]);
      check($sformatf("op%0d_empty", arith_op[i]), empty, 0);
      doop(1);
      check($sformatf("op%0d_pop_empty", arith_op[i]), empty, 1);
      check($sformatf("op%0d_valid", arith_op[i]), valid, 1);
    end

    // Top is the dividend
    push(7); push(86); doop(5);
    check("div_order", tail, 12);
    doop(1);
    push(7); push(86); doop(6);
    check("mod_order", tail, 2);

    // Division by zero
    rst();
    push(0); push(86); doop(5);
    check("div0_valid", valid, 0);
    push(9);
    check("div0_ignored_tail", tail, 86);
    rst();
    check("div0_rst_empty", empty, 1);
    check("div0_rst_valid", valid, 1);
    push(0); push(86); doop(6);
    check("mod0_valid", valid, 0);

    // Underflow and wrap
    rst();
    doop(1);
    check("pop_empty_valid", valid, 0);
    check("pop_empty_empty", empty, 1);
    rst();
    doop(2);
    check("bin_empty_valid", valid, 0);
    check("bin_empty_empty", empty, 1);
    rst();
    push(5); doop(2);
    check("bin1_valid", valid, 0);
    check("bin1_tail",  tail,  5);
    rst();
    push(200); push(100); doop(2);
    check("add_wrap", tail, 44);
    push(3); push(2); doop(4);
    check("sub_wrap", tail, 255);
    push(20); push(13); doop(3);
    check("mul_wrap", tail, 4);

    // Reset wins over an erroring op in the same cycle
    rst();
    repeat (4) push(1);
    cyc(1, 1, 0, 9);
    check("rst_prio_valid", valid, 1);
    check("rst_prio_empty", empty, 1);

    // Reserved op and apply-low hold
    push(3);
    doop(7);
    check("rsvd_tail", tail, 3);
    cyc(0, 0, 1, 0);
    check("noapply_tail", tail, 3);
    check("noapply_valid", valid, 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
